// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: Wishbone fetch FSM feeding a small in-order FIFO.
// One request in flight at most; its FIFO slot is reserved at issue so pushes never overflow.
module instr_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] iwb_adr_o,
  output logic        iwb_cyc_o,
  output logic        iwb_stb_o,
  input  logic [31:0] iwb_dat_i,
  input  logic        iwb_ack_i,
  input  logic        iwb_err_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_err_o,
  input  logic        instr_ready_i
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [31:0] NOP  = 32'h00000013;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, HALT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, adr_q, redirect_pc;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [DEPTH-1:0] mem_err;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          term, push, pop, issue;

  assign redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
  assign term        = iwb_ack_i | iwb_err_i;
  assign pop         = (count != '0) && instr_ready_i && !redirect_i;

  // Redirect wins over ack/pop; a redirect that coincides with the
  // terminating ack goes straight to IDLE since nothing is left to drain.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    issue        = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_nxt = redirect_pc;
        end else if (count < FULL) begin
          issue     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (redirect_i) begin
          fetch_pc_nxt = redirect_pc;
          state_nxt    = term ? IDLE : DRAIN;
        end else if (term) begin
          push = 1'b1;
          if (iwb_err_i) begin
            state_nxt = HALT;
          end else begin
            state_nxt    = IDLE;
            fetch_pc_nxt = fetch_pc + 32'd4;
          end
        end
      end
      DRAIN: begin
        if (redirect_i) fetch_pc_nxt = redirect_pc;
        if (term) state_nxt = IDLE;
      end
      HALT: begin
        if (redirect_i) begin
          fetch_pc_nxt = redirect_pc;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      adr_q    <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (issue) adr_q <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= iwb_err_i ? NOP : iwb_dat_i;
      mem_pc[wr_ptr]    <= adr_q;
      mem_err[wr_ptr]   <= iwb_err_i;
    end
  end

  assign iwb_cyc_o     = (state == BUSY) || (state == DRAIN);
  assign iwb_stb_o     = iwb_cyc_o;
  assign iwb_adr_o     = adr_q;
  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? mem_instr[rd_ptr] : NOP;
  assign instr_pc_o    = instr_valid_o ? mem_pc[rd_ptr] : 32'h0;
  assign instr_err_o   = instr_valid_o && mem_err[rd_ptr];

endmodule
